// File: rtl/button_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | button_pkg : shared channel state enum and parameter defaults              |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
package button_pkg;

   localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;
   localparam int unsigned REPEAT_DELAY_DEF    = 25000000;
   localparam int unsigned REPEAT_PERIOD_DEF   = 5000000;
   localparam int unsigned NUM_KEYS            = 4;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_PRESS_DB   = 2'd1,
      ST_HELD       = 2'd2,
      ST_RELEASE_DB = 2'd3
   } btn_state_e;

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/button_channel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | button_channel : synchronizer, debounce FSM and autorepeat for one key     |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
module button_channel
   import button_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
   parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
   input  logic clk_clk,
   input  logic reset_reset,
   input  logic btn_n_i,
   input  logic repeat_en_i,
   output logic level_o,
   output logic press_o,
   output logic release_o
);

   localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned RP_W = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);

   localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DB_W-1:0] DB_MAX   = DB_W'(DEBOUNCE_CYCLES);
   localparam logic [RP_W-1:0] RP_FIRST = RP_W'(REPEAT_DELAY - 1);
   localparam logic [RP_W-1:0] RP_NEXT  = RP_W'(REPEAT_PERIOD - 1);
   localparam logic [RP_W-1:0] RP_MAX   = RP_W'(max2(REPEAT_DELAY, REPEAT_PERIOD));

   btn_state_e      state_q, state_d;
   logic [1:0]      sync_q, sync_d;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   logic [RP_W-1:0] rep_cnt_q, rep_cnt_d;
   logic            rep_armed_q, rep_armed_d;
   logic            level_q, level_d;
   logic            press_q, press_d;
   logic            release_q, release_d;

   logic            sample;
   logic [DB_W-1:0] db_inc;
   logic [RP_W-1:0] rep_inc;
   logic [RP_W-1:0] rep_target;

   always_comb begin
      sync_d      = {sync_q[0], ~btn_n_i};
      sample      = sync_q[1];
      db_inc      = (db_cnt_q >= DB_MAX) ? db_cnt_q : db_cnt_q + DB_W'(1);
      rep_inc     = (rep_cnt_q >= RP_MAX) ? rep_cnt_q : rep_cnt_q + RP_W'(1);
      // The first repeat waits the long delay, later ones use the period
      rep_target  = rep_armed_q ? RP_NEXT : RP_FIRST;

      state_d     = state_q;
      db_cnt_d    = db_cnt_q;
      rep_cnt_d   = rep_cnt_q;
      rep_armed_d = rep_armed_q;
      level_d     = level_q;
      press_d     = 1'b0;
      release_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (sample) begin
               state_d  = ST_PRESS_DB;
               db_cnt_d = '0;
            end
         end
         ST_PRESS_DB: begin
            if (!sample) begin
               state_d = ST_IDLE;
            end else if (db_cnt_q >= DB_LAST) begin
               state_d     = ST_HELD;
               level_d     = 1'b1;
               press_d     = 1'b1;
               rep_cnt_d   = '0;
               rep_armed_d = 1'b0;
            end else begin
               db_cnt_d = db_inc;
            end
         end
         ST_HELD: begin
            if (!sample) begin
               state_d  = ST_RELEASE_DB;
               db_cnt_d = '0;
            end else if (repeat_en_i) begin
               if (rep_cnt_q >= rep_target) begin
                  press_d     = !press_q;
                  rep_cnt_d   = '0;
                  rep_armed_d = 1'b1;
               end else begin
                  rep_cnt_d = rep_inc;
               end
            end
         end
         ST_RELEASE_DB: begin
            // Repeat counter is left untouched here so a bounce resumes the cadence
            if (sample) begin
               state_d = ST_HELD;
            end else if (db_cnt_q >= DB_LAST) begin
               state_d   = ST_IDLE;
               level_d   = 1'b0;
               release_d = 1'b1;
            end else begin
               db_cnt_d = db_inc;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (!repeat_en_i) begin
         rep_cnt_d   = '0;
         rep_armed_d = 1'b0;
      end
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state_q     <= ST_IDLE;
         sync_q      <= '0;
         db_cnt_q    <= '0;
         rep_cnt_q   <= '0;
         rep_armed_q <= 1'b0;
         level_q     <= 1'b0;
         press_q     <= 1'b0;
         release_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync_q      <= sync_d;
         db_cnt_q    <= db_cnt_d;
         rep_cnt_q   <= rep_cnt_d;
         rep_armed_q <= rep_armed_d;
         level_q     <= level_d;
         press_q     <= press_d;
         release_q   <= release_d;
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | button_conditioner : four independent debounced push-button channels       |
// | Revision           : 1.0                                                   |
// +----------------------------------------------------------------------------+
module button_conditioner
   import button_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
   parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
   input  logic                clk_clk,
   input  logic                reset_reset,
   input  logic [NUM_KEYS-1:0] btn_n_i,
   input  logic                repeat_en_i,
   output logic [NUM_KEYS-1:0] btn_level_o,
   output logic [NUM_KEYS-1:0] btn_press_o,
   output logic [NUM_KEYS-1:0] btn_release_o,
   output logic [NUM_KEYS-1:0] button_external_connection_export
);

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      button_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_channel (
         .clk_clk     (clk_clk),
         .reset_reset (reset_reset),
         .btn_n_i     (btn_n_i[i]),
         .repeat_en_i (repeat_en_i),
         .level_o     (btn_level_o[i]),
         .press_o     (btn_press_o[i]),
         .release_o   (btn_release_o[i])
      );
   end

   assign button_external_connection_export = btn_level_o;

endmodule
`default_nettype wire
